cache_data_array: RTL and testbench

- Parametrised next-generation data array for one cache way. Holds BANK_NUM word-wide banks per line and INDEX_W-addressed lines, with byte-granular store writes to one bank.
- Adds what the earlier data array lacked:
  - registered read with a valid flag;
  - write-first read/write collision handling;
  - a burst refill engine that fills a whole line, one bank per accepted beat, over a valid/ready handshake.
- Sits between the cache controller (store, refill start), the memory interface (refill beats) and the hit/select logic (read data).

---
 rtl/cache_data_array.sv | 122 ++++++++++++
 tb/tb_cache_data_array.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_array.sv
// cache_data_array: one cache way's data array with byte-enable stores, a registered write-first read and a beat-per-bank line refill engine
// Ports: rd_* registered line read (1-cycle latency, rd_valid_o flags fresh data);
//        st_* byte-enabled store into one bank, dropped while busy_o;
//        refill_* start/valid/ready burst, beat k to bank k, refill_done_o pulses after the last beat;
//        busy_o high while a refill is in progress.
module cache_data_array #(
    parameter int DATA_WIDTH = 32,
    parameter int BANK_NUM = 4,
    parameter int INDEX_W = 8,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int CNT_W = $clog2(BANK_NUM),
    localparam int BO_W = $clog2(BYTES),
    localparam int OFFSET_W = CNT_W + BO_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rd_en_i,
    input  logic [INDEX_W-1:0]             rd_index_i,
    output logic [BANK_NUM*DATA_WIDTH-1:0] rd_data_o,
    output logic                           rd_valid_o,
    input  logic                           st_en_i,
    input  logic [INDEX_W-1:0]             st_index_i,
    input  logic [OFFSET_W-1:0]            st_offset_i,
    input  logic [BYTES-1:0]               st_be_i,
    input  logic [DATA_WIDTH-1:0]          st_data_i,
    input  logic                           refill_start_i,
    input  logic [INDEX_W-1:0]             refill_index_i,
    input  logic                           refill_valid_i,
    input  logic [DATA_WIDTH-1:0]          refill_data_i,
    output logic                           refill_ready_o,
    output logic                           refill_done_o,
    output logic                           busy_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [DATA_WIDTH-1:0] mem [2**INDEX_W][BANK_NUM];

    logic [0:0]                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [INDEX_W-1:0]             idx_q, idx_d;
    logic                           done_q, done_d;
    logic [BANK_NUM*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                           rd_valid_q, rd_valid_d;

    logic                           fill, beat, last, wr_en;
    logic [INDEX_W-1:0]             wr_index;
    logic [CNT_W-1:0]               wr_bank;
    logic [BYTES-1:0]               wr_be;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic [BANK_NUM*DATA_WIDTH-1:0] rd_line;

    // Single write port: the store owns it in IDLE, the refill beat in FILL.
    always_comb begin
        fill = state_q == FILL;
        beat = fill & refill_valid_i;
        last = cnt_q == CNT_W'(BANK_NUM - 1);
        wr_en = beat | (st_en_i & ~fill);
        wr_index = fill ? idx_q : st_index_i;
        wr_bank = fill ? cnt_q : CNT_W'(st_offset_i >> BO_W);
        wr_be = fill ? {BYTES{1'b1}} : st_be_i;
        wr_data = fill ? refill_data_i : st_data_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        done_d = beat & last;
        if (!fill && refill_start_i) begin
            state_d = FILL;
            cnt_d = '0;
            idx_d = refill_index_i;
        end else if (beat) begin
            state_d = last ? IDLE : FILL;
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Write-first: bytes being written this edge to the line being read bypass the array.
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < BANK_NUM; k++)
            rd_line[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_index_i][k];
        for (int b = 0; b < BYTES; b++)
            if (wr_en && wr_index == rd_index_i && wr_be[b])
                rd_line[int'(wr_bank)*DATA_WIDTH + b*8 +: 8] = wr_data[b*8 +: 8];
        rd_data_d = rd_en_i ? rd_line : rd_data_q;
        rd_valid_d = rd_en_i;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < BYTES; b++)
                if (wr_be[b])
                    mem[wr_index][wr_bank][b*8 +: 8] <= wr_data[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            done_q <= 1'b0;
            rd_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            done_q <= done_d;
            rd_data_q <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign refill_ready_o = fill;
    assign busy_o = fill;
    assign refill_done_o = done_q;
endmodule

// File: tb/tb_cache_data_array.sv
// tb_cache_data_array: scoreboard bench for cache_data_array at default parameters
module tb_cache_data_array;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_en_i;
    logic [7:0]   rd_index_i;
    logic [127:0] rd_data_o;
    logic         rd_valid_o;
    logic         st_en_i;
    logic [7:0]   st_index_i;
    logic [3:0]   st_offset_i;
    logic [3:0]   st_be_i;
    logic [31:0]  st_data_i;
    logic         refill_start_i;
    logic [7:0]   refill_index_i;
    logic         refill_valid_i;
    logic [31:0]  refill_data_i;
    logic         refill_ready_o;
    logic         refill_done_o;
    logic         busy_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [127:0] exp_q[$];
    logic [127:0] model [256];
    logic [127:0] got;

    always #5 clk = ~clk;

    cache_data_array dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en_i(rd_en_i), .rd_index_i(rd_index_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .st_en_i(st_en_i), .st_index_i(st_index_i), .st_offset_i(st_offset_i), .st_be_i(st_be_i), .st_data_i(st_data_i),
        .refill_start_i(refill_start_i), .refill_index_i(refill_index_i), .refill_valid_i(refill_valid_i),
        .refill_data_i(refill_data_i), .refill_ready_o(refill_ready_o), .refill_done_o(refill_done_o), .busy_o(busy_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_store(input logic [7:0] idx, input logic [3:0] off, input logic [3:0] be, input logic [31:0] data);
        logic [127:0] line;
        line = model[idx];
        for (int b = 0; b < 4; b++)
            if (be[b]) line[int'(off[3:2])*32 + b*8 +: 8] = data[b*8 +: 8];
        model[idx] = line;
    endtask

    task automatic store(input logic [7:0] idx, input logic [3:0] off, input logic [3:0] be, input logic [31:0] data, input bit takes);
        st_en_i = 1'b1;
        st_index_i = idx;
        st_offset_i = off;
        st_be_i = be;
        st_data_i = data;
        if (takes) model_store(idx, off, be, data);
        tick();
        st_en_i = 1'b0;
    endtask

    task automatic init_line(input logic [7:0] idx);
        for (int k = 0; k < 4; k++) store(idx, 4'(k * 4), 4'hF, 32'h0, 1'b1);
    endtask

    task automatic issue_read(input logic [7:0] idx);
        exp_q.push_back(model[idx]);
        rd_en_i = 1'b1;
        rd_index_i = idx;
        tick();
        rd_en_i = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        rd_en_i = 1'b1;
        rd_index_i = 8'h05;
        refill_start_i = 1'b1;
        refill_index_i = 8'h70;
        tick();
        rd_en_i = 1'b0;
        refill_start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1 || rd_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: busy=%b valid=%b expected 1 1", busy_o, rd_valid_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd_valid_o !== 1'b0 || busy_o !== 1'b0 || refill_ready_o !== 1'b0 || refill_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b busy=%b ready=%b done=%b expected 0 0 0 0",
                     rd_valid_o, busy_o, refill_ready_o, refill_done_o);
        end
        n_checks++;
        if (rd_data_o !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: rd_data=%h expected 0", rd_data_o);
        end
        #1 rst_n = 1'b1;
        tick();
        rd_en_i = 1'b1;
        rd_index_i = 8'h05;
        tick();
        rd_en_i = 1'b0;
        n_checks++;
        if (rd_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL read_latency: valid=%b expected 1", rd_valid_o);
        end
        tick();
        n_checks++;
        if (rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_clear: valid=%b expected 0", rd_valid_o);
        end
    endtask

    task automatic test_byte_store;
        init_line(8'h12);
        store(8'h12, 4'h6, 4'b1100, 32'hAABBCCDD, 1'b1);
        issue_read(8'h12);
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== got || rd_data_o !== 128'h00000000_00000000_AABB0000_00000000) begin
            n_fail++;
            $display("FAIL byte_store: rd_data=%h valid=%b expected %h valid=1", rd_data_o, rd_valid_o, got);
        end
        store(8'h12, 4'h6, 4'b0000, 32'h12345678, 1'b1);
        issue_read(8'h12);
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== got) begin
            n_fail++;
            $display("FAIL zero_be_store: rd_data=%h expected %h", rd_data_o, got);
        end
    endtask

    task automatic test_refill_gaps;
        refill_start_i = 1'b1;
        refill_index_i = 8'h40;
        tick();
        refill_start_i = 1'b0;
        refill_index_i = 8'h00;
        n_checks++;
        if (busy_o !== 1'b1 || refill_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_start: busy=%b ready=%b expected 1 1", busy_o, refill_ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                refill_valid_i = 1'b0;
                store(8'h40, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0);
                tick();
                n_checks++;
                if (busy_o !== 1'b1 || refill_done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL refill_gap: busy=%b done=%b expected 1 0", busy_o, refill_done_o);
                end
            end
            refill_valid_i = 1'b1;
            refill_data_i = 32'h11111111 * (k + 1);
            tick();
            n_checks++;
            if (refill_done_o !== (k == 3) || busy_o !== (k != 3) || refill_ready_o !== (k != 3)) begin
                n_fail++;
                $display("FAIL refill_beat%0d: done=%b busy=%b ready=%b expected %b %b %b",
                         k, refill_done_o, busy_o, refill_ready_o, k == 3, k != 3, k != 3);
            end
        end
        refill_valid_i = 1'b0;
        model[8'h40] = 128'h44444444_33333333_22222222_11111111;
        tick();
        n_checks++;
        if (refill_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single_pulse: done=%b expected 0", refill_done_o);
        end
        issue_read(8'h40);
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== got) begin
            n_fail++;
            $display("FAIL refill_line: rd_data=%h expected %h", rd_data_o, got);
        end
    endtask

    task automatic test_collision;
        model_store(8'h12, 4'h0, 4'b0001, 32'h000000EE);
        exp_q.push_back(model[8'h12]);
        rd_en_i = 1'b1;
        rd_index_i = 8'h12;
        st_en_i = 1'b1;
        st_index_i = 8'h12;
        st_offset_i = 4'h0;
        st_be_i = 4'b0001;
        st_data_i = 32'h000000EE;
        tick();
        rd_en_i = 1'b0;
        st_en_i = 1'b0;
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o[7:0] !== 8'hEE || rd_data_o !== got) begin
            n_fail++;
            $display("FAIL collision: rd_data=%h expected %h", rd_data_o, got);
        end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(model[8'h12]);
        exp_q.push_back(model[8'h40]);
        rd_en_i = 1'b1;
        rd_index_i = 8'h12;
        tick();
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== got) begin
            n_fail++;
            $display("FAIL b2b_first: rd_data=%h expected %h", rd_data_o, got);
        end
        rd_index_i = 8'h40;
        tick();
        rd_en_i = 1'b0;
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== got) begin
            n_fail++;
            $display("FAIL b2b_second: rd_data=%h expected %h", rd_data_o, got);
        end
        tick();
        n_checks++;
        if (rd_valid_o !== 1'b0 || rd_data_o !== model[8'h40]) begin
            n_fail++;
            $display("FAIL read_hold: valid=%b rd_data=%h expected 0 %h", rd_valid_o, rd_data_o, model[8'h40]);
        end
    endtask

    task automatic test_reset_midfill;
        init_line(8'h50);
        refill_start_i = 1'b1;
        refill_index_i = 8'h50;
        st_en_i = 1'b1;
        st_index_i = 8'h12;
        st_offset_i = 4'h8;
        st_be_i = 4'b0001;
        st_data_i = 32'h0000005A;
        model_store(8'h12, 4'h8, 4'b0001, 32'h0000005A);
        tick();
        refill_start_i = 1'b0;
        st_en_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            refill_valid_i = 1'b1;
            refill_data_i = 32'hAAAA0001 + k;
            model_store(8'h50, 4'(k * 4), 4'hF, 32'hAAAA0001 + k);
            tick();
        end
        refill_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || refill_ready_o !== 1'b0 || refill_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midfill_reset: busy=%b ready=%b done=%b expected 0 0 0", busy_o, refill_ready_o, refill_done_o);
        end
        #1 rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || refill_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midfill_after: busy=%b done=%b expected 0 0", busy_o, refill_done_o);
        end
        issue_read(8'h50);
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== got) begin
            n_fail++;
            $display("FAIL partial_line: rd_data=%h expected %h", rd_data_o, got);
        end
        issue_read(8'h12);
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== got) begin
            n_fail++;
            $display("FAIL store_with_start: rd_data=%h expected %h", rd_data_o, got);
        end
        refill_start_i = 1'b1;
        refill_index_i = 8'h50;
        tick();
        refill_start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            refill_valid_i = 1'b1;
            refill_data_i = 32'hC0DE0000 + k;
            model_store(8'h50, 4'(k * 4), 4'hF, 32'hC0DE0000 + k);
            tick();
        end
        refill_valid_i = 1'b0;
        n_checks++;
        if (refill_done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_after_reset: done=%b busy=%b expected 1 0", refill_done_o, busy_o);
        end
        issue_read(8'h50);
        got = exp_q.pop_front();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== got) begin
            n_fail++;
            $display("FAIL refilled_line: rd_data=%h expected %h", rd_data_o, got);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rd_en_i = 1'b0;
        rd_index_i = '0;
        st_en_i = 1'b0;
        st_index_i = '0;
        st_offset_i = '0;
        st_be_i = '0;
        st_data_i = '0;
        refill_start_i = 1'b0;
        refill_index_i = '0;
        refill_valid_i = 1'b0;
        refill_data_i = '0;
        for (int i = 0; i < 256; i++) model[i] = '0;
        #12 rst_n = 1'b1;
        test_reset();
        test_byte_store();
        test_refill_gaps();
        test_collision();
        test_back_to_back();
        test_reset_midfill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
